// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC burst splitter: FSM states, descriptor control fields,
// AXI burst and response encodings.
package axi_llc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [7:0] len;
        logic       last;
        logic [1:0] resp;
        logic [7:0] idx;
    } desc_ctrl_t;

endpackage

// File: rtl/axi_llc_burst_splitter_if.sv
// Ax request / split-descriptor bus. master = upstream + descriptor consumer,
// slave = the splitter.
interface axi_llc_burst_splitter_if #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdWidth   = 6,
    parameter int unsigned UserWidth = 4,
    parameter int unsigned NumWays   = 8
);
    logic                 ax_valid_i;
    logic                 ax_ready_o;
    logic [AddrWidth-1:0] ax_addr_i;
    logic [7:0]           ax_len_i;
    logic [2:0]           ax_size_i;
    logic [1:0]           ax_burst_i;
    logic [IdWidth-1:0]   ax_id_i;
    logic [UserWidth-1:0] ax_user_i;

    logic                 desc_valid_o;
    logic                 desc_ready_i;
    logic [AddrWidth-1:0] desc_addr_o;
    logic [7:0]           desc_len_o;
    logic [2:0]           desc_size_o;
    logic [IdWidth-1:0]   desc_id_o;
    logic [UserWidth-1:0] desc_user_o;
    logic                 desc_last_o;
    logic                 desc_spm_o;
    logic [NumWays-1:0]   desc_way_o;
    logic [1:0]           desc_resp_o;
    logic [7:0]           desc_idx_o;

    modport master (
        output ax_valid_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, ax_id_i, ax_user_i,
        output desc_ready_i,
        input  ax_ready_o,
        input  desc_valid_o, desc_addr_o, desc_len_o, desc_size_o, desc_id_o, desc_user_o,
        input  desc_last_o, desc_spm_o, desc_way_o, desc_resp_o, desc_idx_o
    );

    modport slave (
        input  ax_valid_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, ax_id_i, ax_user_i,
        input  desc_ready_i,
        output ax_ready_o,
        output desc_valid_o, desc_addr_o, desc_len_o, desc_size_o, desc_id_o, desc_user_o,
        output desc_last_o, desc_spm_o, desc_way_o, desc_resp_o, desc_idx_o
    );
endinterface

// File: rtl/axi_llc_split_decode.sv
// Combinational region decode of one split address: cached range, one of NumWays
// SPM way windows, or unmapped (SLVERR on way 0).
module axi_llc_split_decode
    import axi_llc_pkg::*;
#(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned NumWays   = 8,
    parameter logic [63:0] WayBytes  = 64'h2_0000
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [AddrWidth-1:0] i_cached_start,
    input  logic [AddrWidth-1:0] i_cached_end,
    input  logic [AddrWidth-1:0] i_spm_start,
    output logic                 o_spm,
    output logic [NumWays-1:0]   o_way,
    output logic [1:0]           o_resp
);
    localparam logic [AddrWidth-1:0] WaySz = AddrWidth'(WayBytes);

    logic               w_cached;
    logic [NumWays-1:0] w_hit;

    assign w_cached = (i_addr >= i_cached_start) && (i_addr < i_cached_end);

    for (genvar k = 0; k < NumWays; k++) begin : g_way
        logic [AddrWidth-1:0] w_lo;
        logic [AddrWidth-1:0] w_hi;
        assign w_lo     = i_spm_start + AddrWidth'(k) * WaySz;
        assign w_hi     = w_lo + WaySz;
        assign w_hit[k] = (i_addr >= w_lo) && (i_addr < w_hi);
    end

    // Way windows are disjoint, so the hit vector is already one-hot.
    always_comb begin
        o_spm  = 1'b1;
        o_way  = NumWays'(1);
        o_resp = RESP_SLVERR;
        if (w_cached) begin
            o_spm  = 1'b0;
            o_way  = '0;
            o_resp = RESP_OKAY;
        end else if (|w_hit) begin
            o_way  = w_hit;
            o_resp = RESP_OKAY;
        end
    end
endmodule

// File: rtl/axi_llc_burst_splitter.sv
// Splits AXI Ax bursts into per-cache-line descriptors tagged with region/way.
// Define AXI_LLC_SPLIT_WRAP_EN to split WRAP bursts; otherwise WRAP is passed whole with SLVERR.
module axi_llc_burst_splitter
    import axi_llc_pkg::*;
#(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdWidth    = 6,
    parameter int unsigned UserWidth  = 4,
    parameter int unsigned LineOffset = 7,
    parameter int unsigned NumWays    = 8,
    parameter logic [63:0] WayBytes   = 64'h2_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   cached_start_i,
    input  logic [AddrWidth-1:0]   cached_end_i,
    input  logic [AddrWidth-1:0]   spm_start_i,
    axi_llc_burst_splitter_if.slave bus
);
    localparam logic [AddrWidth-1:0] LineMask = AddrWidth'((64'd1 << LineOffset) - 64'd1);

    state_e               r_state, w_state_nxt;
    logic [AddrWidth-1:0] r_addr;
    logic [7:0]           r_len;
    logic [7:0]           r_idx;
    logic [2:0]           r_size;
    logic [1:0]           r_burst;
    logic [IdWidth-1:0]   r_id;
    logic [UserWidth-1:0] r_user;

    logic                 w_ax_hs, w_desc_hs, w_split, w_more;
    logic [AddrWidth-1:0] w_line_end, w_seg_end, w_next_addr, w_beats;
    logic                 w_spm;
    logic [NumWays-1:0]   w_way;
    logic [1:0]           w_dec_resp;
    desc_ctrl_t           w_desc;

    assign bus.ax_ready_o   = (r_state == ST_IDLE) && !rst_i;
    assign bus.desc_valid_o = (r_state == ST_SPLIT);
    assign w_ax_hs          = bus.ax_valid_i && bus.ax_ready_o;
    assign w_desc_hs        = bus.desc_valid_o && bus.desc_ready_i;
    assign w_line_end       = (r_addr | LineMask) + AddrWidth'(1);

`ifdef AXI_LLC_SPLIT_WRAP_EN
    logic [AddrWidth-1:0] r_wrap_lo, r_wrap_hi, w_wrap_bytes, w_ax_wrap_lo;
    logic                 w_wrap;

    assign w_wrap       = (r_burst == BURST_WRAP);
    assign w_wrap_bytes = (AddrWidth'(bus.ax_len_i) + AddrWidth'(1)) << bus.ax_size_i;
    assign w_ax_wrap_lo = bus.ax_addr_i & ~(w_wrap_bytes - AddrWidth'(1));
    // A segment ends at the line end or the wrap boundary, whichever comes first.
    assign w_seg_end    = (w_wrap && (r_wrap_hi < w_line_end)) ? r_wrap_hi : w_line_end;
    assign w_next_addr  = (w_wrap && (w_seg_end == r_wrap_hi)) ? r_wrap_lo : w_seg_end;
    assign w_split      = (r_burst == BURST_INCR) || w_wrap;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrap_lo <= '0;
            r_wrap_hi <= '0;
        end else if (w_ax_hs) begin
            r_wrap_lo <= w_ax_wrap_lo;
            r_wrap_hi <= w_ax_wrap_lo + w_wrap_bytes;
        end
    end
`else
    assign w_seg_end   = w_line_end;
    assign w_next_addr = w_line_end;
    assign w_split     = (r_burst == BURST_INCR);
`endif

    assign w_beats = ((w_seg_end - r_addr - AddrWidth'(1)) >> r_size) + AddrWidth'(1);
    assign w_more  = w_split && (w_beats <= AddrWidth'(r_len));

    axi_llc_split_decode #(
        .AddrWidth (AddrWidth),
        .NumWays   (NumWays),
        .WayBytes  (WayBytes)
    ) u_dec (
        .i_addr         (r_addr),
        .i_cached_start (cached_start_i),
        .i_cached_end   (cached_end_i),
        .i_spm_start    (spm_start_i),
        .o_spm          (w_spm),
        .o_way          (w_way),
        .o_resp         (w_dec_resp)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_desc      = '0;
        w_desc.idx  = r_idx;
        w_desc.len  = w_more ? (w_beats[7:0] - 8'd1) : r_len;
        w_desc.last = !w_more;
        w_desc.resp = w_dec_resp;
`ifndef AXI_LLC_SPLIT_WRAP_EN
        if (r_burst == BURST_WRAP) w_desc.resp = RESP_SLVERR;
`endif
        case (r_state)
            ST_IDLE:  if (w_ax_hs) w_state_nxt = ST_SPLIT;
            ST_SPLIT: if (w_desc_hs && !w_more) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_id    <= '0;
            r_user  <= '0;
        end else if (w_ax_hs) begin
            r_addr  <= bus.ax_addr_i;
            r_len   <= bus.ax_len_i;
            r_idx   <= '0;
            r_size  <= bus.ax_size_i;
            r_burst <= bus.ax_burst_i;
            r_id    <= bus.ax_id_i;
            r_user  <= bus.ax_user_i;
        end else if (w_desc_hs && w_more) begin
            r_addr  <= w_next_addr;
            r_len   <= r_len - w_beats[7:0];
            r_idx   <= r_idx + 8'd1;
        end
    end

    assign bus.desc_addr_o = r_addr;
    assign bus.desc_len_o  = w_desc.len;
    assign bus.desc_size_o = r_size;
    assign bus.desc_id_o   = r_id;
    assign bus.desc_user_o = r_user;
    assign bus.desc_last_o = w_desc.last;
    assign bus.desc_spm_o  = w_spm;
    assign bus.desc_way_o  = w_way;
    assign bus.desc_resp_o = w_desc.resp;
    assign bus.desc_idx_o  = w_desc.idx;

    // Beat sizes wider than a cache line are an upstream precondition violation.
    a_size_fits_line: assert property (@(posedge clk_i) disable iff (rst_i)
        w_ax_hs |-> (32'(bus.ax_size_i) <= LineOffset));
endmodule

// File: tb/tb_axi_llc_burst_splitter.sv
// Directed bench for axi_llc_burst_splitter: line splits, FIXED/WRAP, region decode,
// back-pressure hold and mid-burst reset.
module tb_axi_llc_burst_splitter;
    import axi_llc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cstart = 64'h0;
    logic [63:0] cend   = 64'h1_0000;
    logic [63:0] sstart = 64'h10_0000;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [5:0]  g_id   = 6'd0;
    logic [3:0]  g_user = 4'd0;
    logic [2:0]  g_size = 3'd0;

    always #5 clk = ~clk;

    axi_llc_burst_splitter_if bus ();

    axi_llc_burst_splitter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cached_start_i (cstart),
        .cached_end_i   (cend),
        .spm_start_i    (sstart),
        .bus            (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ax(input string tag, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        while (!bus.ax_ready_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ardy"}, 64'(bus.ax_ready_o), 64'd1);
        g_id   = g_id + 6'd1;
        g_user = g_id[3:0] ^ 4'h5;
        g_size = size;
        bus.ax_valid_i = 1'b1;
        bus.ax_addr_i  = addr;
        bus.ax_len_i   = len;
        bus.ax_size_i  = size;
        bus.ax_burst_i = burst;
        bus.ax_id_i    = g_id;
        bus.ax_user_i  = g_user;
        tick();
        bus.ax_valid_i = 1'b0;
    endtask

    task automatic exp_desc(input string tag, input logic [63:0] addr, input logic [7:0] len,
                            input logic last, input logic [7:0] idx, input logic spm,
                            input logic [7:0] way, input logic [1:0] resp, input bit hs);
        int n = 0;
        while (!bus.desc_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 64'(bus.desc_valid_o), 64'd1);
        chk({tag, "_addr"}, bus.desc_addr_o, addr);
        chk({tag, "_ctl"},
            64'({bus.desc_len_o, bus.desc_last_o, bus.desc_idx_o, bus.desc_spm_o, bus.desc_way_o,
                 bus.desc_resp_o, bus.desc_size_o, bus.desc_id_o, bus.desc_user_o}),
            64'({len, last, idx, spm, way, resp, g_size, g_id, g_user}));
        if (hs) tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_idle_ardy"}, 64'(bus.ax_ready_o), 64'd1);
        chk({tag, "_idle_dvld"}, 64'(bus.desc_valid_o), 64'd0);
    endtask

    initial begin
        bus.ax_valid_i   = 1'b0;
        bus.ax_addr_i    = '0;
        bus.ax_len_i     = '0;
        bus.ax_size_i    = '0;
        bus.ax_burst_i   = '0;
        bus.ax_id_i      = '0;
        bus.ax_user_i    = '0;
        bus.desc_ready_i = 1'b1;

        repeat (3) tick();
        chk("rst_ardy", 64'(bus.ax_ready_o), 64'd0);
        chk("rst_dvld", 64'(bus.desc_valid_o), 64'd0);
        chk("rst_addr", bus.desc_addr_o, 64'd0);
        chk("rst_idx", 64'(bus.desc_idx_o), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_ardy", 64'(bus.ax_ready_o), 64'd1);
        tick();

        // Whole burst fits in one line.
        send_ax("t1", 64'h1000, 8'd15, 3'd3, BURST_INCR);
        chk("t1_lat", 64'(bus.desc_valid_o), 64'd1);
        chk("t1_busy_ardy", 64'(bus.ax_ready_o), 64'd0);
        exp_desc("t1", 64'h1000, 8'd15, 1'b1, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk_idle("t1");

        // Crosses one line boundary after two beats.
        send_ax("t2", 64'h1070, 8'd3, 3'd3, BURST_INCR);
        exp_desc("t2a", 64'h1070, 8'd1, 1'b0, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        exp_desc("t2b", 64'h1080, 8'd1, 1'b1, 8'd1, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk_idle("t2");

        // 4-byte beats: 31 beats to the line end, 10 on the next line.
        send_ax("t2s", 64'h1004, 8'd40, 3'd2, BURST_INCR);
        exp_desc("t2sa", 64'h1004, 8'd30, 1'b0, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        exp_desc("t2sb", 64'h1080, 8'd9, 1'b1, 8'd1, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk_idle("t2s");

        // FIXED is never split; descriptor must hold under back-pressure.
        bus.desc_ready_i = 1'b0;
        send_ax("t3", 64'h10F8, 8'd7, 3'd3, BURST_FIXED);
        for (int i = 0; i < 5; i++) begin
            exp_desc("t3_hold", 64'h10F8, 8'd7, 1'b1, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b0);
            chk("t3_hold_ardy", 64'(bus.ax_ready_o), 64'd0);
            tick();
        end
        bus.desc_ready_i = 1'b1;
        exp_desc("t3", 64'h10F8, 8'd7, 1'b1, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk_idle("t3");

        send_ax("t4", 64'h1040, 8'd31, 3'd3, BURST_WRAP);
`ifdef AXI_LLC_SPLIT_WRAP_EN
        exp_desc("t4a", 64'h1040, 8'd7, 1'b0, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        exp_desc("t4b", 64'h1080, 8'd15, 1'b0, 8'd1, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        exp_desc("t4c", 64'h1000, 8'd7, 1'b1, 8'd2, 1'b0, 8'h00, RESP_OKAY, 1'b1);
`else
        exp_desc("t4", 64'h1040, 8'd31, 1'b1, 8'd0, 1'b0, 8'h00, RESP_SLVERR, 1'b1);
`endif
        chk_idle("t4");

        // SPM way 2, then an unmapped address.
        send_ax("t5", 64'h14_0000, 8'd0, 3'd3, BURST_INCR);
        exp_desc("t5", 64'h14_0000, 8'd0, 1'b1, 8'd0, 1'b1, 8'h04, RESP_OKAY, 1'b1);
        send_ax("t5u", 64'hFFFF_0000, 8'd0, 3'd3, BURST_INCR);
        exp_desc("t5u", 64'hFFFF_0000, 8'd0, 1'b1, 8'd0, 1'b1, 8'h01, RESP_SLVERR, 1'b1);
        chk_idle("t5");

        // Reset in the middle of a three-line burst.
        send_ax("t6", 64'h1000, 8'd47, 3'd3, BURST_INCR);
        exp_desc("t6a", 64'h1000, 8'd15, 1'b0, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk("t6_pre_idx", 64'(bus.desc_idx_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_dvld", 64'(bus.desc_valid_o), 64'd0);
        chk("t6_rst_ardy", 64'(bus.ax_ready_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_idle("t6_rel");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_quiet", 64'(bus.desc_valid_o), 64'd0);
        end
        send_ax("t6n", 64'h1070, 8'd0, 3'd3, BURST_INCR);
        exp_desc("t6n", 64'h1070, 8'd0, 1'b1, 8'd0, 1'b0, 8'h00, RESP_OKAY, 1'b1);
        chk_idle("t6n");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
